d_reg_pipe: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds a per-stage valid bit, shift enable (stall), flush, parallel load and an occupancy count.
- Used as the generic delay/retiming element between lab datapath blocks.
- DEPTH=1, WIDTH=1 with en tied high and flush/load tied low behaves as a plain D flip-flop.

---
 rtl/d_reg_pipe_if.sv | 24 ++
 rtl/d_reg_pipe.sv | 47 ++++
 tb/tb_d_reg_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/d_reg_pipe_if.sv
// d_reg_pipe_if: control, data and status bundle for the register pipeline
interface d_reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                       en;
  logic                       flush;
  logic                       load;
  logic [WIDTH-1:0]           din;
  logic                       din_vld;
  logic [WIDTH*DEPTH-1:0]     pdin;
  logic [WIDTH-1:0]           dout;
  logic                       dout_vld;
  logic [WIDTH*DEPTH-1:0]     taps;
  logic [$clog2(DEPTH+1)-1:0] occ;
  modport master (
    output en, flush, load, din, din_vld, pdin,
    input  dout, dout_vld, taps, occ
  );
  modport slave (
    input  en, flush, load, din, din_vld, pdin,
    output dout, dout_vld, taps, occ
  );
endinterface

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: WIDTH x DEPTH register pipeline with valid tags, stall, flush, parallel load and occupancy
module d_reg_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  d_reg_pipe_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [OW-1:0]    occ_c;
  // stage update, priority rst > flush > load > en > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) data[k] <= RST_VAL;
      vld <= '0;
    end else if (bus.flush) begin
      vld <= '0;
    end else if (bus.load) begin
      for (int k = 0; k < DEPTH; k++) data[k] <= bus.pdin[k*WIDTH +: WIDTH];
      vld <= '1;
    end else if (bus.en) begin
      data[0] <= bus.din;
      vld[0]  <= bus.din_vld;
      for (int k = 1; k < DEPTH; k++) begin
        data[k] <= data[k-1];
        vld[k]  <= vld[k-1];
      end
    end
  end
  // occupancy is a popcount of the registered valid bits
  always_comb begin
    occ_c = '0;
    for (int k = 0; k < DEPTH; k++) occ_c = occ_c + OW'(vld[k]);
  end
  // expose every stage on the flat tap bus
  always_comb begin
    bus.taps = '0;
    for (int k = 0; k < DEPTH; k++) bus.taps[k*WIDTH +: WIDTH] = data[k];
  end
  assign bus.dout     = data[DEPTH-1];
  assign bus.dout_vld = vld[DEPTH-1];
  assign bus.occ      = occ_c;
endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: directed scoreboard bench for d_reg_pipe (WIDTH=8, DEPTH=4, RST_VAL=A5)
module tb_d_reg_pipe;
  typedef struct {
    logic [7:0]  dout;
    logic        vld;
    logic [31:0] taps;
    logic [2:0]  occ;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  d_reg_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();
  d_reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  // drive one edge's inputs at the falling edge and queue the state expected after the next rising edge
  task automatic step(input logic r, input logic e, input logic f, input logic l,
                      input logic [7:0] d, input logic dv, input logic [31:0] pd,
                      input logic [7:0] ed, input logic ev, input logic [31:0] et, input logic [2:0] eo);
    exp_t x;
    @(negedge clk);
    rst = r; bus.en = e; bus.flush = f; bus.load = l;
    bus.din = d; bus.din_vld = dv; bus.pdin = pd;
    x.dout = ed; x.vld = ev; x.taps = et; x.occ = eo;
    q.push_back(x);
  endtask
  // monitor: pops one expectation per rising edge once the stimulus has queued it
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        cmp("dout", 32'(bus.dout), 32'(x.dout));
        cmp("dout_vld", 32'(bus.dout_vld), 32'(x.vld));
        cmp("taps", bus.taps, x.taps);
        cmp("occ", 32'(bus.occ), 32'(x.occ));
      end
    end
  end
  initial begin
    int n;
    bus.en = 0; bus.flush = 0; bus.load = 0;
    bus.din = '0; bus.din_vld = 0; bus.pdin = '0;
    //    r e f l din   dv pdin          dout  v taps          occ
    step(1,0,0,0,8'h00,0,32'h0,        8'hA5,0,32'hA5A5A5A5,3'd0);
    step(1,0,0,0,8'h00,0,32'h0,        8'hA5,0,32'hA5A5A5A5,3'd0);
    step(0,1,0,0,8'h11,1,32'h0,        8'hA5,0,32'hA5A5A511,3'd1);
    step(0,1,0,0,8'h22,1,32'h0,        8'hA5,0,32'hA5A51122,3'd2);
    step(0,1,0,0,8'h33,1,32'h0,        8'hA5,0,32'hA5112233,3'd3);
    step(0,1,0,0,8'h44,1,32'h0,        8'h11,1,32'h11223344,3'd4);
    step(0,1,0,0,8'h55,1,32'h0,        8'h22,1,32'h22334455,3'd4);
    step(0,1,0,0,8'h66,1,32'h0,        8'h33,1,32'h33445566,3'd4);
    step(1,1,0,0,8'h77,1,32'h0,        8'hA5,0,32'hA5A5A5A5,3'd0);
    step(0,1,0,0,8'h11,1,32'h0,        8'hA5,0,32'hA5A5A511,3'd1);
    step(0,1,0,0,8'h22,1,32'h0,        8'hA5,0,32'hA5A51122,3'd2);
    step(0,1,0,0,8'h33,1,32'h0,        8'hA5,0,32'hA5112233,3'd3);
    step(0,1,0,0,8'h44,1,32'h0,        8'h11,1,32'h11223344,3'd4);
    step(0,0,0,0,8'hEE,1,32'h0,        8'h11,1,32'h11223344,3'd4);
    step(0,0,0,0,8'hEF,0,32'h0,        8'h11,1,32'h11223344,3'd4);
    step(0,0,0,0,8'hF0,1,32'h0,        8'h11,1,32'h11223344,3'd4);
    step(0,1,0,0,8'h55,1,32'h0,        8'h22,1,32'h22334455,3'd4);
    step(0,1,0,0,8'h66,0,32'h0,        8'h33,1,32'h33445566,3'd3);
    step(0,1,1,0,8'h77,1,32'h0,        8'h33,0,32'h33445566,3'd0);
    step(0,1,1,1,8'h88,1,32'h12345678, 8'h33,0,32'h33445566,3'd0);
    step(0,1,0,1,8'h00,1,32'h44332211, 8'h44,1,32'h44332211,3'd4);
    step(0,1,0,0,8'h99,0,32'h0,        8'h33,1,32'h33221199,3'd3);
    step(0,1,0,0,8'h00,1,32'h0,        8'h22,1,32'h2211995A,3'd3);
    #4 bus.din = 8'h5A;
    #2 bus.din = 8'hC3;
    step(1,1,0,1,8'h77,1,32'hDEADBEEF, 8'hA5,0,32'hA5A5A5A5,3'd0);
    step(0,1,0,0,8'hE1,1,32'h0,        8'hA5,0,32'hA5A5A5E1,3'd1);
    step(0,1,0,0,8'hE2,0,32'h0,        8'hA5,0,32'hA5A5E1E2,3'd1);
    step(0,1,0,0,8'hE3,0,32'h0,        8'hA5,0,32'hA5E1E2E3,3'd1);
    step(0,1,0,0,8'hE4,0,32'h0,        8'hE1,1,32'hE1E2E3E4,3'd1);
    @(negedge clk);
    bus.en = 0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
